// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter/receiver state encoding and
// helpers for deriving the bit period and counter/pointer widths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    // Clocks per bit; integer division, so the line rate rounds up slightly.
    function automatic int baud_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Bits needed to index 'value' items; never less than 1 so that
    // degenerate counters still have a legal width.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_pixel_tx_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head word is held in a
// register so dout is valid in every cycle where empty is low.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic [WIDTH-1:0] dout_reg;
    logic             full_reg;
    logic             empty_reg;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    always_comb begin
        do_pop      = pop && !empty_reg;
        do_push     = push && (!full_reg || do_pop);
        rd_ptr_next = rd_ptr_reg + PTR_W'(do_pop);
        count_next  = count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Storage write port; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers, occupancy flags and the registered head word. When the
    // incoming word lands on the next head slot it bypasses the array.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            dout_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            full_reg   <= (count_next == CNT_W'(DEPTH));
            empty_reg  <= (count_next == '0);
            dout_reg   <= (do_push && (wr_ptr_reg == rd_ptr_next)) ? din : mem[rd_ptr_next];
        end
    end

    assign dout  = dout_reg;
    assign full  = full_reg;
    assign empty = empty_reg;

endmodule

// File: rtl/uart_pixel_tx.sv
// Buffered 8N1 UART transmitter for processed pixels. Strobed bytes are
// queued in a small FIFO and sent LSB-first; consecutive queued bytes go
// out as contiguous frames.
module uart_pixel_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       pi_flag,
    input  logic [7:0] pi_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       fifo_full,
    output logic       drop_flag
);

    localparam int BAUD_CNT = baud_cnt(CLK_FREQ, BAUD);
    localparam int CNT_W    = clog2(BAUD_CNT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CNT - 1);

    uart_state_t      state_reg;
    logic [CNT_W-1:0] baud_cnt_reg;
    logic [2:0]       bit_cnt_reg;
    logic [7:0]       shift_reg;
    logic             tx_reg;
    logic             busy_reg;
    logic             drop_reg;

    logic [7:0]       fifo_dout;
    logic             fifo_empty;
    logic             fifo_is_full;
    logic             bit_end;
    logic             pop;

    // A byte leaves the FIFO either from IDLE or at the last clock of a
    // stop bit, which is what makes back-to-back frames gapless.
    always_comb begin
        bit_end = (baud_cnt_reg == BAUD_LAST);
        pop     = !fifo_empty && ((state_reg == IDLE) || ((state_reg == STOP) && bit_end));
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sclk),
        .srst  (rst),
        .push  (pi_flag),
        .pop   (pop),
        .din   (pi_data),
        .dout  (fifo_dout),
        .full  (fifo_is_full),
        .empty (fifo_empty)
    );

    // Frame sequencer with its baud counter, bit counter and shift register.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    baud_cnt_reg <= '0;
                    if (pop) begin
                        shift_reg   <= fifo_dout;
                        bit_cnt_reg <= '0;
                        state_reg   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        state_reg    <= DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        shift_reg    <= {1'b0, shift_reg[7:1]};
                        bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= STOP;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        if (pop) begin
                            shift_reg   <= fifo_dout;
                            bit_cnt_reg <= '0;
                            state_reg   <= START;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Registered line and status outputs; tx follows the sequencer by one clock.
    always_ff @(posedge sclk) begin
        if (rst) begin
            tx_reg   <= 1'b1;
            busy_reg <= 1'b0;
            drop_reg <= 1'b0;
        end else begin
            case (state_reg)
                START:   tx_reg <= 1'b0;
                DATA:    tx_reg <= shift_reg[0];
                default: tx_reg <= 1'b1;
            endcase
            busy_reg <= (state_reg != IDLE) || !fifo_empty;
            drop_reg <= pi_flag && fifo_is_full && !pop;
        end
    end

    assign tx        = tx_reg;
    assign tx_busy   = busy_reg;
    assign fifo_full = fifo_is_full;
    assign drop_flag = drop_reg;

endmodule

// File: tb/tb_uart_pixel_tx.sv
// Scoreboard bench for uart_pixel_tx: a cycle-level reference model
// predicts accepted bytes, frame start times and status flags; a separate
// line monitor decodes tx and compares against the predictions.
module tb_uart_pixel_tx;

    localparam int CLK_FREQ   = 1000;
    localparam int BAUD       = 100;
    localparam int FIFO_DEPTH = 4;
    localparam int BAUD_CNT   = CLK_FREQ / BAUD;
    localparam int FRAME      = 10 * BAUD_CNT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pi_flag = 1'b0;
    logic [7:0] pi_data = 8'h00;
    logic       tx;
    logic       tx_busy;
    logic       fifo_full;
    logic       drop_flag;

    uart_pixel_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .sclk      (clk),
        .rst       (rst),
        .pi_flag   (pi_flag),
        .pi_data   (pi_data),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .fifo_full (fifo_full),
        .drop_flag (drop_flag)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, actual, required, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [7:0] b;
        int         start;
    } frame_t;

    frame_t     exp_q[$];
    logic [7:0] mq[$];
    int         edge_idx  = 0;
    int         last_pop  = -1000;
    bit         exp_drop  = 1'b0;
    bit         exp_full  = 1'b0;
    bit         exp_busy  = 1'b0;
    bit         prev_busy = 1'b0;

    // At every clock: a queued byte starts a frame once the previous frame
    // has occupied its full 10 bit times; writes are kept while room exists
    // or a byte leaves in the same clock.
    initial begin
        bit         full_before;
        bit         do_pop;
        bit         do_drop;
        frame_t     f;
        forever begin
            @(posedge clk);
            edge_idx++;
            if (rst) begin
                mq.delete();
                exp_q.delete();
                last_pop  = -1000;
                exp_drop  = 1'b0;
                exp_full  = 1'b0;
                exp_busy  = 1'b0;
                prev_busy = 1'b0;
            end else begin
                exp_busy    = prev_busy;
                full_before = (mq.size() == FIFO_DEPTH);
                do_pop      = (mq.size() > 0) && (edge_idx >= last_pop + FRAME);
                do_drop     = 1'b0;
                if (do_pop) begin
                    f.b     = mq.pop_front();
                    f.start = edge_idx + 1;
                    exp_q.push_back(f);
                    last_pop = edge_idx;
                end
                if (pi_flag) begin
                    if (full_before && !do_pop) begin
                        do_drop = 1'b1;
                    end else begin
                        mq.push_back(pi_data);
                    end
                end
                exp_drop  = do_drop;
                exp_full  = (mq.size() == FIFO_DEPTH);
                prev_busy = (edge_idx <= last_pop + FRAME - 1) || (mq.size() > 0);
            end
        end
    end

    // ---------------- line monitor ----------------
    bit   in_frame   = 1'b0;
    int   nsamp      = 0;
    int   start_edge = 0;
    logic samp [FRAME];

    task automatic finish_frame();
        frame_t     f;
        logic [7:0] decoded;
        int         bad;
        logic       want;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: actual frame at edge %0d required none", start_edge);
            return;
        end
        f = exp_q.pop_front();
        bad = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i < BAUD_CNT)                 want = 1'b0;
            else if (i < 9 * BAUD_CNT)        want = f.b[(i - BAUD_CNT) / BAUD_CNT];
            else                              want = 1'b1;
            if (samp[i] !== want) bad++;
        end
        for (int k = 0; k < 8; k++) begin
            decoded[k] = samp[BAUD_CNT * (k + 1) + BAUD_CNT / 2];
        end
        $display("frame @edge %0d: byte %02h (expected %02h at edge %0d)", start_edge, decoded, f.b, f.start);
        check("frame_byte", decoded, f.b);
        check("frame_shape_bad_samples", bad, 0);
        check("frame_start_edge", start_edge, f.start);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame && (tx === 1'b0)) begin
                    in_frame   = 1'b1;
                    nsamp      = 0;
                    start_edge = edge_idx;
                end
                if (in_frame) begin
                    samp[nsamp] = tx;
                    nsamp++;
                    if (nsamp == FRAME) begin
                        finish_frame();
                        in_frame = 1'b0;
                    end
                end
            end
            check("drop_flag", drop_flag, exp_drop);
            check("fifo_full", fifo_full, exp_full);
            check("tx_busy", tx_busy, exp_busy);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        pi_flag = 1'b1;
        pi_data = b;
        tick();
        pi_flag = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (!(mq.size() == 0 && exp_q.size() == 0 && !in_frame &&
                 edge_idx >= last_pop + FRAME + 3) && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain_within_budget", (n < max_cycles), 1);
    endtask

    initial begin
        int s;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_tx", tx, 1);
        check("reset_busy", tx_busy, 0);
        check("reset_full", fifo_full, 0);
        check("reset_drop", drop_flag, 0);

        // Line idle after reset.
        repeat (500) begin
            tick();
            check("idle_tx", tx, 1);
        end

        // Single byte.
        send(8'h55);
        wait_idle(400);

        // Burst on consecutive cycles.
        send(8'h00);
        send(8'hFF);
        send(8'hA5);
        wait_idle(600);

        // Overflow: six writes while idle.
        for (int i = 0; i < 6; i++) send(8'($urandom));
        wait_idle(800);

        // Write while full coinciding with the stop-end pop.
        s = edge_idx + 1;
        for (int i = 0; i < 5; i++) send(8'($urandom));
        while (edge_idx + 1 < s + FRAME + 1) tick();
        send(8'($urandom));
        send(8'($urandom));
        wait_idle(1000);

        // Reset during DATA with bytes queued.
        send(8'h3C);
        send(8'($urandom));
        send(8'($urandom));
        repeat (40) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_tx", tx, 1);
        check("midreset_busy", tx_busy, 0);
        repeat (300) tick();
        send(8'($urandom));
        wait_idle(400);

        // Random sparse traffic.
        repeat (600) begin
            if ($urandom_range(0, 24) == 0) send(8'($urandom));
            else tick();
        end
        wait_idle(1000);

        repeat (150) tick();
        check("leftover_expected_frames", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_pixel_tx.md
# uart_pixel_tx

Buffered UART transmitter for the image return path. Accepts processed 8-bit pixels from the Sobel pipeline as single-cycle strobes, queues them in a small FIFO, and serialises each byte as 8N1 (start, 8 data LSB-first, stop) on `tx` at a fixed baud rate. It is the transmit-side counterpart of the pixel receive path, so edge-map results can be streamed back to the host without stalling the pipeline.

## Interface
- `CLK_FREQ`, 50_000_000: `sclk` frequency in Hz.
- `BAUD`, 9600: line rate in bit/s. `BAUD_CNT = CLK_FREQ/BAUD` (integer division) is the number of clocks per bit.
- `FIFO_DEPTH`, 16: byte slots, power of two, at least 2.
- `sclk`  in  1  system clock. Single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `pi_flag`  in  1  one-cycle strobe: `pi_data` is valid this cycle.
- `pi_data`  in  8  pixel byte to transmit.
- `tx`  out  1  serial line, idle high.
- `tx_busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `drop_flag`  out  1  one-cycle pulse when a byte is discarded because the FIFO was full.

## Operation
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit counter, go to START.
  - START: `tx`=0 for `BAUD_CNT` clocks, then go to DATA.
  - DATA: `tx`=shift[0] for `BAUD_CNT` clocks per bit. Shift right after each bit. After bit index 7, go to STOP.
  - STOP: `tx`=1 for `BAUD_CNT` clocks. At the last clock:
    - FIFO non-empty: pop and go directly to START, giving back-to-back frames with no idle gap.
    - FIFO empty: go to IDLE.
- Baud counter:
  - Runs 0..`BAUD_CNT`-1 in START, DATA and STOP.
  - Wraps to 0 on each bit boundary.
  - Is held at 0 in IDLE.
- Bit counter: 3 bits, counts data bits 0..7.
- FIFO write: when `pi_flag`=1 and the FIFO is not full.
- Write while full:
  - If a pop occurs in the same cycle, the write is accepted and occupancy is unchanged.
  - Otherwise the byte is discarded and `drop_flag`=1 in the next cycle.
- Simultaneous push and pop on an empty FIFO cannot occur, because a pop requires non-empty registered state.
- `tx_busy` = (state != IDLE) OR FIFO non-empty.
- `tx` is driven from a flop, so the output is glitch-free.

## Timing
- Values during/after reset:
  - `tx`=1, `tx_busy`=0, `fifo_full`=0, `drop_flag`=0.
  - FSM in IDLE; FIFO pointers and count are 0.
- Reset mid-frame: the line returns high on the next clock. The partial frame is abandoned and not resent, and queued bytes are discarded.
- Latency from an idle, empty block: `pi_flag` sampled at edge N → FIFO non-empty after N → pop at N+1 → `tx` falls after edge N+2.
- Frame length is exactly `10*BAUD_CNT` clocks. Back-to-back frames are contiguous.
- `fifo_full` and `drop_flag` are registered and update one clock after the causing edge.
- `pi_data` is sampled only on cycles where `pi_flag`=1.

## Structure
- `uart_pkg` holds:
  - the state enum (IDLE/START/DATA/STOP);
  - the `BAUD_CNT` derivation;
  - a `clog2` helper for counter and pointer widths.
  - It is shared with the receive path.
- Sub-module `sync_fifo` (parameters: width 8, `FIFO_DEPTH`):
  - ports: push, pop, din, dout, full, empty;
  - one-word-per-cycle push/pop;
  - registered `dout` available in the cycle `empty`=0, first-word-fall-through.
- Top-level: FSM, baud counter, bit counter, shift register.

## Test plan
All scenarios use `CLK_FREQ`=1000, `BAUD`=100 (`BAUD_CNT`=10), `FIFO_DEPTH`=4.
- Single byte 0x55: one `pi_flag` → `tx` low from cycle 2 to 11, then data 1,0,1,0,1,0,1,0 at 10 clocks each, stop high for 10, then IDLE. `tx_busy` falls at cycle 102.
- Burst 0x00, 0xFF, 0xA5 on consecutive cycles → three contiguous frames of 100 clocks each with no gap. Decoded bytes match in order.
- Overflow: 6 writes on consecutive cycles while idle.
  - The first byte is popped at cycle 1; the next 4 fill the FIFO and `fifo_full`=1.
  - The 6th is dropped with a single-cycle `drop_flag` pulse.
  - Exactly 5 frames are sent.
- Push while full during a STOP-end pop → the write is accepted, `drop_flag` stays 0, and order is preserved.
- Assert `rst` for 1 cycle during DATA of 0x3C with 2 bytes queued → `tx`=1 next cycle, `tx_busy`=0, no further frames are sent; a new write afterwards is sent correctly.
- Line idle check: no `pi_flag` for 500 cycles after reset → `tx` constantly 1 and `tx_busy`=0.
